cpu_control_fsm: RTL and testbench

Multi-cycle successor to the single-cycle main control decoder. It sequences each RV32I instruction through FETCH, DECODE, EXEC, MEM and WB states, and holds the instruction opcode in a register. Instruction and data memory accesses use a req/ready handshake with a parametrised timeout. The block adds JALR support, illegal-opcode and bus-timeout traps, and a retired-instruction counter. It sits between the instruction register, the datapath muxes/ALU and the memory ports.

---
 rtl/cpu_control_fsm_if.sv | 24 ++
 rtl/cpu_control_fsm.sv | 89 ++++++++
 tb/tb_cpu_control_fsm.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_control_fsm_if.sv
// cpu_control_fsm_if: signal bundle between the multi-cycle controller and the
// instruction register, datapath and memory ports.
interface cpu_control_fsm_if #(parameter int CNT_W = 32);
  logic [6:0] instruction;
  logic imem_ready, dmem_ready, trap_clear;
  logic imem_req, dmem_req, ir_write;
  logic MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, Branch;
  logic [2:0] ALUOp;
  logic [1:0] fetchPC;
  logic pc_write, pc_write_cond, retire;
  logic [CNT_W-1:0] instret;
  logic trap;
  logic [1:0] trap_cause;
  modport master (
    input instruction, imem_ready, dmem_ready, trap_clear,
    output imem_req, dmem_req, ir_write, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, Branch,
    output ALUOp, fetchPC, pc_write, pc_write_cond, retire, instret, trap, trap_cause
  );
  modport slave (
    output instruction, imem_ready, dmem_ready, trap_clear,
    input imem_req, dmem_req, ir_write, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, Branch,
    input ALUOp, fetchPC, pc_write, pc_write_cond, retire, instret, trap, trap_cause
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle RV32I control sequencer with bus-timeout and
// illegal-opcode traps and a retired-instruction counter.
module cpu_control_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 32,
  parameter int EN_JALR = 1
) (
  input logic clk,
  input logic rst,
  cpu_control_fsm_if.master ctrl
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [6:0] OP_R = 7'b0110011, OP_IMM = 7'b0010011, OP_LW = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;
  state_e state_q, state_d;
  logic [6:0] op_q;
  logic [WW-1:0] wait_q;
  logic [CNT_W-1:0] instret_q;
  logic [1:0] cause_q, cause_d;
  logic on, timeout, legal, retire, st_done;
  logic is_r, is_imm, is_lw, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc;
  logic ex, wb;
  assign is_r = op_q == OP_R;
  assign is_imm = op_q == OP_IMM;
  assign is_lw = op_q == OP_LW;
  assign is_s = op_q == OP_S;
  assign is_b = op_q == OP_B;
  assign is_jal = op_q == OP_JAL;
  assign is_jalr = op_q == OP_JALR;
  assign is_lui = op_q == OP_LUI;
  assign is_auipc = op_q == OP_AUIPC;
  assign legal = (ctrl.instruction inside {OP_R, OP_IMM, OP_LW, OP_S, OP_B, OP_JAL, OP_LUI, OP_AUIPC})
              || (EN_JALR != 0 && ctrl.instruction == OP_JALR);
  assign timeout = wait_q == WW'(TIMEOUT);
  assign on = !rst;
  assign ex = on && state_q == EXEC;
  assign wb = on && state_q == WB;
  assign st_done = on && state_q == MEM && is_s && ctrl.dmem_ready;
  assign retire = (ex && is_b) || st_done || wb;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: state_d = ctrl.imem_ready ? DECODE : timeout ? TRAP : FETCH;
      DECODE: state_d = legal ? EXEC : TRAP;
      EXEC: state_d = is_b ? FETCH : (is_lw || is_s) ? MEM : WB;
      MEM: state_d = ctrl.dmem_ready ? (is_lw ? WB : FETCH) : timeout ? TRAP : MEM;
      WB: state_d = FETCH;
      TRAP: state_d = ctrl.trap_clear ? FETCH : TRAP;
      default: state_d = FETCH;
    endcase
    // Cause is captured on TRAP entry and dropped when TRAP is left.
    cause_d = state_d != TRAP ? 2'b00
            : state_q != TRAP ? (state_q == DECODE ? 2'b10 : 2'b01) : cause_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      op_q <= '0;
      wait_q <= '0;
      instret_q <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wait_q <= state_d != state_q ? '0 : wait_q + WW'(1);
      if (state_q == DECODE) op_q <= ctrl.instruction;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end
  assign ctrl.imem_req = on && state_q == FETCH;
  assign ctrl.ir_write = on && state_q == FETCH && ctrl.imem_ready;
  assign ctrl.dmem_req = on && state_q == MEM;
  assign ctrl.MemRead = on && state_q == MEM && is_lw;
  assign ctrl.MemWrite = on && state_q == MEM && is_s;
  assign ctrl.MemtoReg = wb && is_lw;
  assign ctrl.RegWrite = wb;
  assign ctrl.ALUSrc = ex && (is_s || is_lw || is_imm || is_lui || is_auipc || is_jalr);
  assign ctrl.ALUOp = ex ? {is_r, is_jal || is_imm, is_b || is_jal} : 3'b000;
  assign ctrl.Branch = ex && (is_b || is_jal || is_jalr);
  assign ctrl.fetchPC = wb ? {is_auipc, is_jal || is_jalr} : 2'b00;
  assign ctrl.pc_write = wb || st_done;
  assign ctrl.pc_write_cond = ex && is_b;
  assign ctrl.retire = retire;
  assign ctrl.trap = on && state_q == TRAP;
  assign ctrl.trap_cause = on ? cause_q : 2'b00;
  assign ctrl.instret = on ? instret_q : '0;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed plus randomized instruction streams against a
// per-opcode reference table; dut0 has JALR and 32-bit count, dut1 neither.
module tb_cpu_control_fsm;
  localparam int TO = 15;
  localparam logic [6:0] R = 7'b0110011, IMM = 7'b0010011, LW = 7'b0000011, S = 7'b0100011;
  localparam logic [6:0] B = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0, rst1, sel;
  logic [6:0] instruction;
  logic imem_ready, dmem_ready, trap_clear;
  logic [31:0] exp_cnt;
  int checks = 0, errors = 0;
  cpu_control_fsm_if #(.CNT_W(32)) if0();
  cpu_control_fsm_if #(.CNT_W(4)) if1();
  cpu_control_fsm #(.TIMEOUT(TO), .CNT_W(32), .EN_JALR(1)) dut0(.clk(clk), .rst(rst0), .ctrl(if0));
  cpu_control_fsm #(.TIMEOUT(TO), .CNT_W(4), .EN_JALR(0)) dut1(.clk(clk), .rst(rst1), .ctrl(if1));
  assign if0.instruction = instruction;
  assign if0.imem_ready = imem_ready;
  assign if0.dmem_ready = dmem_ready;
  assign if0.trap_clear = trap_clear;
  assign if1.instruction = instruction;
  assign if1.imem_ready = imem_ready;
  assign if1.dmem_ready = dmem_ready;
  assign if1.trap_clear = trap_clear;
  logic [19:0] all0, all1, o;
  logic [31:0] cnt;
  assign all0 = {if0.imem_req, if0.dmem_req, if0.ir_write, if0.MemRead, if0.MemWrite, if0.MemtoReg,
                 if0.ALUSrc, if0.RegWrite, if0.Branch, if0.ALUOp, if0.fetchPC, if0.pc_write,
                 if0.pc_write_cond, if0.retire, if0.trap, if0.trap_cause};
  assign all1 = {if1.imem_req, if1.dmem_req, if1.ir_write, if1.MemRead, if1.MemWrite, if1.MemtoReg,
                 if1.ALUSrc, if1.RegWrite, if1.Branch, if1.ALUOp, if1.fetchPC, if1.pc_write,
                 if1.pc_write_cond, if1.retire, if1.trap, if1.trap_cause};
  assign o = sel ? all1 : all0;
  assign cnt = sel ? {28'b0, if1.instret} : if0.instret;
  // kind: 0 retires in EXEC, 1 load, 2 store, 3 ALU-style ending in WB
  typedef struct packed {
    logic legal;
    logic alusrc;
    logic [2:0] aluop;
    logic branch;
    logic [1:0] fpc;
    logic [1:0] kind;
  } info_t;
  function automatic info_t info(input logic [6:0] op, input logic en_jalr);
    case (op)
      R:       return '{1'b1, 1'b0, 3'b100, 1'b0, 2'b00, 2'd3};
      IMM:     return '{1'b1, 1'b1, 3'b010, 1'b0, 2'b00, 2'd3};
      LW:      return '{1'b1, 1'b1, 3'b000, 1'b0, 2'b00, 2'd1};
      S:       return '{1'b1, 1'b1, 3'b000, 1'b0, 2'b00, 2'd2};
      B:       return '{1'b1, 1'b0, 3'b001, 1'b1, 2'b00, 2'd0};
      JAL:     return '{1'b1, 1'b0, 3'b011, 1'b1, 2'b01, 2'd3};
      JALR:    return '{en_jalr, 1'b1, 3'b000, 1'b1, 2'b01, 2'd3};
      LUI:     return '{1'b1, 1'b1, 3'b000, 1'b0, 2'b00, 2'd3};
      AUIPC:   return '{1'b1, 1'b1, 3'b000, 1'b0, 2'b10, 2'd3};
      default: return '{1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 2'd0};
    endcase
  endfunction
  function automatic logic [19:0] ov(input logic ireq, dreq, irw, mr, mw, m2r, as, rw, br,
      input logic [2:0] aop, input logic [1:0] fpc, input logic pw, pwc, ret, tr,
      input logic [1:0] cs);
    return {ireq, dreq, irw, mr, mw, m2r, as, rw, br, aop, fpc, pw, pwc, ret, tr, cs};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic logic [31:0] exp_instret();
    return sel ? {28'b0, exp_cnt[3:0]} : exp_cnt;
  endfunction
  task automatic step(input logic ir, dr, tc, input logic [6:0] ins);
    @(negedge clk);
    imem_ready = ir;
    dmem_ready = dr;
    trap_clear = tc;
    instruction = ins;
    #1;
  endtask
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  task automatic do_trap(input logic [1:0] cause);
    int n = $urandom_range(0, 2);
    for (int k = 0; k <= n; k++) begin
      step(rb(), rb(), k == n, 7'($urandom));
      chk("trap", {12'b0, o}, {12'b0, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b0, 2'b0, 0, 0, 0, 1, cause)});
    end
  endtask
  task automatic run_instr(input logic [6:0] op, input int iw, input int dw);
    info_t m = info(op, !sel);
    logic st;
    for (int k = 0; k <= iw && k <= TO; k++) begin
      step(k == iw, rb(), rb(), 7'($urandom));
      chk("fetch", {12'b0, o}, {12'b0, ov(1, 0, k == iw, 0, 0, 0, 0, 0, 0, 3'b0, 2'b0, 0, 0, 0, 0, 2'b0)});
      if (k == 0) chk("instret", cnt, exp_instret());
    end
    if (iw > TO) begin do_trap(2'b01); return; end
    step(rb(), rb(), rb(), op);
    chk("decode", {12'b0, o}, 32'h0);
    if (!m.legal) begin do_trap(2'b10); return; end
    step(rb(), rb(), rb(), 7'($urandom));
    chk("exec", {12'b0, o}, {12'b0, ov(0, 0, 0, 0, 0, 0, m.alusrc, 0, m.branch, m.aluop, 2'b0,
        0, m.kind == 0, m.kind == 0, 0, 2'b0)});
    if (m.kind == 0) begin exp_cnt++; return; end
    if (m.kind != 3) begin
      for (int k = 0; k <= dw && k <= TO; k++) begin
        step(rb(), k == dw, rb(), 7'($urandom));
        st = m.kind == 2 && k == dw;
        chk("mem", {12'b0, o}, {12'b0, ov(0, 1, 0, m.kind == 1, m.kind == 2, 0, 0, 0, 0, 3'b0, 2'b0,
            st, 0, st, 0, 2'b0)});
      end
      if (dw > TO) begin do_trap(2'b01); return; end
      if (m.kind == 2) begin exp_cnt++; return; end
    end
    step(rb(), rb(), rb(), 7'($urandom));
    chk("wb", {12'b0, o}, {12'b0, ov(0, 0, 0, 0, 0, m.kind == 1, 0, 1, 0, 3'b0, m.fpc, 1, 0, 1, 0, 2'b0)});
    exp_cnt++;
  endtask
  logic [6:0] ops [9] = '{R, IMM, LW, S, B, JAL, JALR, LUI, AUIPC};
  initial begin
    sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1; exp_cnt = '0;
    imem_ready = 1'b0; dmem_ready = 1'b0; trap_clear = 1'b0; instruction = '0;
    step(1, 1, 1, R);
    chk("rst_out", {12'b0, o}, 32'h0);
    step(1, 1, 0, R);
    chk("rst_out2", {12'b0, o}, 32'h0);
    chk("rst_cnt", cnt, 32'h0);
    @(posedge clk); #1 rst0 = 1'b0;
    run_instr(R, 0, 0);
    run_instr(LW, 0, 3);
    run_instr(7'b1111111, 0, 0);
    run_instr(B, 0, 0);
    run_instr(IMM, 16, 0);
    run_instr(IMM, 15, 0);
    run_instr(LW, 1, 16);
    run_instr(S, 2, 15);
    run_instr(JALR, 0, 0);
    run_instr(JAL, 0, 0);
    run_instr(AUIPC, 0, 0);
    run_instr(LUI, 0, 0);
    run_instr(7'b0000000, 1, 0);
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 9) == 0 ? 7'($urandom) : ops[$urandom_range(0, 8)],
                $urandom_range(0, 9) == 0 ? 16 : $urandom_range(0, 3),
                $urandom_range(0, 9) == 0 ? 16 : $urandom_range(0, 3));
    step(0, 0, 0, 7'h0);
    chk("cnt0_end", cnt, exp_cnt);
    @(posedge clk); #1;
    rst0 = 1'b1; sel = 1'b1; rst1 = 1'b0; exp_cnt = '0;
    run_instr(JALR, 0, 0);
    for (int i = 0; i < 17; i++) run_instr(B, $urandom_range(0, 2), 0);
    step(1, 0, 0, 7'h0);
    chk("p_fetch", {12'b0, o}, {12'b0, ov(1, 0, 1, 0, 0, 0, 0, 0, 0, 3'b0, 2'b0, 0, 0, 0, 0, 2'b0)});
    chk("wrap", cnt, 32'h1);
    step(0, 0, 0, LW);
    step(0, 0, 0, 7'h0);
    step(0, 0, 0, 7'h0);
    chk("p_mem", {12'b0, o}, {12'b0, ov(0, 1, 0, 1, 0, 0, 0, 0, 0, 3'b0, 2'b0, 0, 0, 0, 0, 2'b0)});
    @(negedge clk);
    rst1 = 1'b1; dmem_ready = 1'b1;
    #1;
    chk("mid_rst_out", {12'b0, o}, 32'h0);
    chk("mid_rst_cnt", cnt, 32'h0);
    @(posedge clk); #1 rst1 = 1'b0; exp_cnt = '0;
    run_instr(R, 0, 0);
    run_instr(S, 0, 1);
    step(0, 0, 0, 7'h0);
    chk("cnt1_end", cnt, 32'h2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
